// File: rtl/alu_pipe_pkg.sv
// Shared types for the pipelined ALU: opcode enum, flag layout, lane helper.
// Imported by alu_pipe and alu_pipe_core.
package alu_pipe_pkg;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_XOR    = 3'd2,
    ALU_RED    = 3'd3,
    ALU_SLL    = 3'd4,
    ALU_SRL    = 3'd5,
    ALU_ROR    = 3'd6,
    ALU_PADDSB = 3'd7
  } alu_op_e;

  localparam int FLAG_N = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;

  typedef logic [2:0] alu_flag_t;

  // Signed 4-bit lane add clamped to [-8, +7].
  function automatic logic [3:0] paddsb_lane(input logic [3:0] x, input logic [3:0] y);
    logic signed [4:0] s;
    logic [3:0]        r;
    s = $signed({x[3], x}) + $signed({y[3], y});
    if (s > 5'sd7) begin
      r = 4'h7;
    end else if (s < -5'sd8) begin
      r = 4'h8;
    end else begin
      r = s[3:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: op/a/b plus current flags -> result and next flags.
// Zero latency; no handshake (sits inside stage 2 of alu_pipe).
// ALU_PIPE_SAT_EN: ADD/SUB clamp to the signed range on overflow instead of wrapping.
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_flag_t        flag_in,
  output logic [WIDTH-1:0] result,
  output alu_flag_t        flag_out
);

`ifdef ALU_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] red_sum;
  logic [WIDTH-1:0] pad_res;
  logic             add_ovf;
  logic             sub_ovf;
  logic             is_arith;
  logic             ovf;
  logic [SHW-1:0]   sh_amt;
  logic [SHW-1:0]   rot_amt;

  assign sum      = a + b;
  assign diff     = a - b;
  // Overflow: operands' signs agree (add) / differ (sub) and the result sign departs from A.
  assign add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
  assign sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  assign is_arith = (op == ALU_ADD) || (op == ALU_SUB);
  assign ovf      = (op == ALU_ADD) ? add_ovf : sub_ovf;
  assign sh_amt   = b[SHW-1:0];
  // The shift field can exceed WIDTH-1 when WIDTH is not a power of two.
  assign rot_amt  = SHW'(32'(sh_amt) % WIDTH);

  // Sum of every signed byte of A and B, wrapped to WIDTH bits.
  always_comb begin
    red_sum = '0;
    for (int i = 0; i < WIDTH / 8; i++) begin
      red_sum = red_sum + WIDTH'($signed(a[8*i +: 8])) + WIDTH'($signed(b[8*i +: 8]));
    end
  end

  // Per-nibble saturating signed add.
  always_comb begin
    pad_res = '0;
    for (int i = 0; i < WIDTH / 4; i++) begin
      pad_res[4*i +: 4] = paddsb_lane(a[4*i +: 4], b[4*i +: 4]);
    end
  end

  // Result mux and flag update; N/V only move on ADD/SUB, Z on every op.
  always_comb begin
    result   = '0;
    flag_out = flag_in;
    case (op)
      ALU_ADD:    result = sum;
      ALU_SUB:    result = diff;
      ALU_XOR:    result = a ^ b;
      ALU_RED:    result = red_sum;
      ALU_SLL:    result = a << sh_amt;
      ALU_SRL:    result = a >> sh_amt;
      // A shift by WIDTH yields zero, so rot_amt=0 degrades cleanly to A.
      ALU_ROR:    result = (a >> rot_amt) | (a << (WIDTH - 32'(rot_amt)));
      ALU_PADDSB: result = pad_res;
      default:    result = '0;
    endcase
`ifdef ALU_PIPE_SAT_EN
    // Overflow direction follows the sign of A for both add and subtract.
    if (is_arith && ovf) begin
      result = a[WIDTH-1] ? SMIN : SMAX;
    end
`endif
    flag_out[FLAG_Z] = (result == '0);
    if (is_arith) begin
      flag_out[FLAG_N] = result[WIDTH-1];
      flag_out[FLAG_V] = ovf;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: stage 1 latches op/operands, stage 2 registers result + N/V/Z flags.
// Latency 2 cycles from the accepting cycle to out_valid; 1 beat/cycle sustained.
// Full backpressure: stage 1 advances only when stage 2 is empty or draining. Macro: ALU_PIPE_SAT_EN.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       out_flag,
  output logic [2:0]       flag_q
);

  logic             s1_valid;
  alu_op_e          s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  alu_flag_t        flag_reg;
  logic             s1_adv;
  logic             in_fire;
  logic [WIDTH-1:0] core_result;
  alu_flag_t        core_flag;

  assign s1_adv   = s1_valid & (~s2_valid | out_ready);
  assign in_ready = ~s1_valid | s1_adv;
  assign in_fire  = in_valid & in_ready;

  // Stage 1: capture the operand beat; drain when it moves into stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= ALU_ADD;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_op    <= alu_op_e'(in_op);
      s1_a     <= in_a;
      s1_b     <= in_b;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // The core sees the flags of the previous op, which gives program-order hold of N/V.
  alu_pipe_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .op       (s1_op),
    .a        (s1_a),
    .b        (s1_b),
    .flag_in  (flag_reg),
    .result   (core_result),
    .flag_out (core_flag)
  );

  // Stage 2: register result and flags on advance; hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      flag_reg  <= '0;
    end else if (s1_adv) begin
      s2_valid  <= 1'b1;
      s2_result <= core_result;
      flag_reg  <= core_flag;
    end else if (out_ready) begin
      s2_valid  <= 1'b0;
    end
  end

  assign out_valid  = s2_valid;
  assign out_result = s2_result;
  assign out_flag   = flag_reg;
  assign flag_q     = flag_reg;

endmodule
